// File: rtl/expu_result_collector.sv
// expu_result_collector
//   Receiving end of the exponential unit's output stream. Lane vectors
//   (data, per-lane strobe, tag) are accepted over a valid/ready handshake,
//   held in a DEPTH-entry FIFO and replayed downstream over a second
//   valid/ready handshake. The upstream ready depends only on local
//   occupancy, so the exponential unit stalls only when the buffer is full.
//   A saturating counter totals the strobed lanes accepted, for softmax
//   denominator bookkeeping.
//
// Optional feature: define EXPU_COLLECTOR_PROTO_CHECK_EN to add proto_err_o,
//   a sticky flag raised when upstream retracts valid_i or changes
//   tag_i/res_i while a vector is stalled.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous flush (pointers, count, lane counter)
//   enable_i             global enable; low blocks push and pop
//   valid_i/ready_o      upstream handshake, res_i/strb_i/tag_i payload
//   valid_o/ready_i      downstream handshake, data_o/strb_o/tag_o payload
//                        (unstrobed lanes of data_o read as zero)
//   lanes_o              saturating count of strobed lanes accepted
//   busy_o               FIFO non-empty
//   proto_err_o          (optional) sticky handshake-protocol violation
module expu_result_collector #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned N_ROWS    = 1,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter type         TAG_TYPE  = logic
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         enable_i,
  input  logic                         valid_i,
  input  logic [N_ROWS*WIDTH-1:0]      res_i,
  input  logic [N_ROWS-1:0]            strb_i,
  input  logic [$bits(TAG_TYPE)-1:0]   tag_i,
  output logic                         ready_o,
  output logic                         valid_o,
  output logic [N_ROWS*WIDTH-1:0]      data_o,
  output logic [N_ROWS-1:0]            strb_o,
  output logic [$bits(TAG_TYPE)-1:0]   tag_o,
  input  logic                         ready_i,
  output logic [CNT_WIDTH-1:0]         lanes_o,
  output logic                         busy_o
`ifdef EXPU_COLLECTOR_PROTO_CHECK_EN
  ,
  output logic                         proto_err_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $bits(TAG_TYPE);
  localparam int unsigned DW = N_ROWS * WIDTH;
  localparam int unsigned PW = $clog2(N_ROWS + 1);
  localparam int unsigned SW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;

  function automatic logic [PW-1:0] popcount(input logic [N_ROWS-1:0] s);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      c = c + PW'(s[i]);
    end
    return c;
  endfunction

  // Sum is formed one bit wider than either operand so overflow is visible,
  // then clamped to the all-ones counter value.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PW-1:0]        b);
    logic [SW-1:0] s;
    logic [SW-1:0] lim;
    lim                  = '0;
    lim[CNT_WIDTH-1:0]   = '1;
    s = SW'(a) + SW'(b);
    if (s > lim) begin
      return '1;
    end
    return s[CNT_WIDTH-1:0];
  endfunction

  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [CW-1:0]        count;
  logic [CNT_WIDTH-1:0] lanes;

  logic [DW-1:0]        mem_data [DEPTH];
  logic [N_ROWS-1:0]    mem_strb [DEPTH];
  logic [TW-1:0]        mem_tag  [DEPTH];

  logic push;
  logic pop;

  // Full blocks acceptance even when a pop happens the same cycle; ready_o
  // never looks at ready_i.
  assign ready_o = enable_i & (count != CW'(DEPTH));
  assign valid_o = (count != '0);
  assign busy_o  = valid_o;
  assign lanes_o = lanes;

  assign push = valid_i & ready_o & ~clear_i;
  assign pop  = valid_o & ready_i & enable_i & ~clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      lanes <= '0;
    end else if (clear_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      lanes <= '0;
    end else begin
      if (push) begin
        wptr  <= wptr + AW'(1);
        lanes <= sat_add(lanes, popcount(strb_i));
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; only the occupancy state qualifies it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wptr] <= res_i;
      mem_strb[wptr] <= strb_i;
      mem_tag[wptr]  <= tag_i;
    end
  end

  always_comb begin
    data_o = '0;
    strb_o = '0;
    tag_o  = '0;
    if (valid_o) begin
      strb_o = mem_strb[rptr];
      tag_o  = mem_tag[rptr];
      for (int i = 0; i < N_ROWS; i++) begin
        if (mem_strb[rptr][i]) begin
          data_o[i*WIDTH +: WIDTH] = mem_data[rptr][i*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef EXPU_COLLECTOR_PROTO_CHECK_EN
  // pend_p0 remembers that last cycle offered a vector that was not taken;
  // the payload captured alongside it must then be re-offered unchanged.
  logic          pend_p0;
  logic [DW-1:0] res_p0;
  logic [TW-1:0] tag_p0;
  logic          err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_p0 <= 1'b0;
      err     <= 1'b0;
    end else if (clear_i) begin
      pend_p0 <= 1'b0;
      err     <= 1'b0;
    end else begin
      pend_p0 <= valid_i & ~ready_o;
      if (pend_p0 && (!valid_i || (tag_i != tag_p0) || (res_i != res_p0))) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    res_p0 <= res_i;
    tag_p0 <= tag_i;
  end

  assign proto_err_o = err;
`endif

endmodule

// File: tb/tb_expu_result_collector.sv
module tb_expu_result_collector;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic        clear, en, vld, rdy;
  logic [31:0] res;
  logic [1:0]  strb;
  logic [3:0]  tag;
  logic        ready, valid, busy;
  logic [31:0] data, lanes;
  logic [1:0]  strb_out;
  logic [3:0]  tag_out;

  logic        clear2, en2, vld2, rdy2;
  logic [31:0] res2;
  logic [1:0]  strb2;
  logic [3:0]  tag2;
  logic        ready2, valid2, busy2;
  logic [31:0] data2;
  logic [3:0]  lanes2;
  logic [1:0]  strb_out2;
  logic [3:0]  tag_out2;
`ifdef EXPU_COLLECTOR_PROTO_CHECK_EN
  logic        perr, perr2;
`endif

  expu_result_collector #(
    .WIDTH(16), .N_ROWS(2), .DEPTH(D), .CNT_WIDTH(32), .TAG_TYPE(logic [3:0])
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear), .enable_i(en),
    .valid_i(vld), .res_i(res), .strb_i(strb), .tag_i(tag),
    .ready_o(ready), .valid_o(valid), .data_o(data), .strb_o(strb_out),
    .tag_o(tag_out), .ready_i(rdy), .lanes_o(lanes), .busy_o(busy)
`ifdef EXPU_COLLECTOR_PROTO_CHECK_EN
    , .proto_err_o(perr)
`endif
  );

  expu_result_collector #(
    .WIDTH(16), .N_ROWS(2), .DEPTH(D), .CNT_WIDTH(4), .TAG_TYPE(logic [3:0])
  ) dut_sat (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear2), .enable_i(en2),
    .valid_i(vld2), .res_i(res2), .strb_i(strb2), .tag_i(tag2),
    .ready_o(ready2), .valid_o(valid2), .data_o(data2), .strb_o(strb_out2),
    .tag_o(tag_out2), .ready_i(rdy2), .lanes_o(lanes2), .busy_o(busy2)
`ifdef EXPU_COLLECTOR_PROTO_CHECK_EN
    , .proto_err_o(perr2)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model: queue of entries + lane total --------
  typedef struct {
    logic [31:0] d;
    logic [1:0]  s;
    logic [3:0]  t;
  } ent_t;

  ent_t            q[$];
  longint unsigned mlanes;

  function automatic logic [31:0] masked(input ent_t e);
    return e.d & {{16{e.s[1]}}, {16{e.s[0]}}};
  endfunction

  task automatic model_cycle(input string nm);
    logic do_push, do_pop;
    ent_t e;
    #1;
    chk({nm, ".ready"}, 64'(ready), 64'(en && (q.size() != D)));
    chk({nm, ".valid"}, 64'(valid), 64'(q.size() != 0));
    chk({nm, ".busy"},  64'(busy),  64'(q.size() != 0));
    chk({nm, ".lanes"}, 64'(lanes), 64'(mlanes));
    if (q.size() != 0) begin
      chk({nm, ".data"}, 64'(data), 64'(masked(q[0])));
      chk({nm, ".strb"}, 64'(strb_out), 64'(q[0].s));
      chk({nm, ".tag"},  64'(tag_out), 64'(q[0].t));
    end else begin
      chk({nm, ".data0"}, 64'({data, strb_out, tag_out}), 64'(0));
    end
    do_push = vld && en && (q.size() != D);
    do_pop  = rdy && en && (q.size() != 0);
    e.d = res; e.s = strb; e.t = tag;
    @(posedge clk);
    #1;
    if (clear) begin
      q.delete();
      mlanes = 0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        mlanes = mlanes + longint'($countones(strb));
        if (mlanes > 64'hFFFF_FFFF) mlanes = 64'hFFFF_FFFF;
      end
    end
  endtask

  task automatic idle_inputs();
    clear = 0; en = 1; vld = 0; rdy = 0; res = '0; strb = '0; tag = '0;
  endtask

  task automatic clear_all();
    idle_inputs();
    clear = 1;
    @(posedge clk);
    #1;
    clear = 0;
    q.delete();
    mlanes = 0;
  endtask

  // ---------------- directed table ----------------------------------------
  typedef struct {
    logic        clr, en, vld;
    logic [31:0] res;
    logic [1:0]  strb;
    logic [3:0]  tag;
    logic        rdy;
    logic        e_ready, e_valid;
    logic [31:0] e_lanes, e_data;
    logic [1:0]  e_strb;
    logic [3:0]  e_tag;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic e, input logic v,
                              input logic [31:0] r, input logic [1:0] s,
                              input logic [3:0] t, input logic rd,
                              input logic er, input logic ev, input logic [31:0] el,
                              input logic [31:0] ed, input logic [1:0] es,
                              input logic [3:0] et);
    vec_t x;
    x.clr = c; x.en = e; x.vld = v; x.res = r; x.strb = s; x.tag = t; x.rdy = rd;
    x.e_ready = er; x.e_valid = ev; x.e_lanes = el; x.e_data = ed;
    x.e_strb = es; x.e_tag = et;
    return x;
  endfunction

  vec_t tbl[24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = mk(0,1,0,32'h0,0,0,0,            1,0,0,32'h0,0,0);
    tbl[1]  = mk(0,1,1,32'h4000_3C00,3,1,0,    1,0,0,32'h0,0,0);
    tbl[2]  = mk(0,1,0,32'h0,0,0,0,            1,1,2,32'h4000_3C00,3,1);
    tbl[3]  = mk(1,1,0,32'h0,0,0,0,            1,1,2,32'h4000_3C00,3,1);
    tbl[4]  = mk(0,1,1,32'h1111_2222,3,2,0,    1,0,0,32'h0,0,0);
    tbl[5]  = mk(0,1,1,32'h3333_4444,1,3,0,    1,1,2,32'h1111_2222,3,2);
    tbl[6]  = mk(0,1,1,32'h5555_6666,2,4,0,    1,1,3,32'h1111_2222,3,2);
    tbl[7]  = mk(0,1,1,32'h7777_8888,3,5,0,    1,1,4,32'h1111_2222,3,2);
    tbl[8]  = mk(0,1,1,32'h9999_AAAA,3,6,0,    0,1,6,32'h1111_2222,3,2);
    tbl[9]  = mk(0,1,1,32'h9999_AAAA,3,6,0,    0,1,6,32'h1111_2222,3,2);
    tbl[10] = mk(0,1,1,32'h9999_AAAA,3,6,1,    0,1,6,32'h1111_2222,3,2);
    tbl[11] = mk(0,1,1,32'h9999_AAAA,3,6,0,    1,1,6,32'h0000_4444,1,3);
    tbl[12] = mk(0,1,0,32'h0,0,0,1,            0,1,8,32'h0000_4444,1,3);
    tbl[13] = mk(0,1,0,32'h0,0,0,1,            1,1,8,32'h5555_0000,2,4);
    tbl[14] = mk(0,1,0,32'h0,0,0,1,            1,1,8,32'h7777_8888,3,5);
    tbl[15] = mk(0,1,0,32'h0,0,0,1,            1,1,8,32'h9999_AAAA,3,6);
    tbl[16] = mk(0,1,0,32'h0,0,0,1,            1,0,8,32'h0,0,0);
    tbl[17] = mk(0,1,1,32'h0101_0202,3,7,0,    1,0,8,32'h0,0,0);
    tbl[18] = mk(0,1,1,32'h0303_0404,1,8,0,    1,1,10,32'h0101_0202,3,7);
    tbl[19] = mk(0,1,1,32'h0505_0606,2,9,0,    1,1,11,32'h0101_0202,3,7);
    tbl[20] = mk(1,1,1,32'h0707_0808,3,10,1,   1,1,12,32'h0101_0202,3,7);
    tbl[21] = mk(0,1,0,32'h0,0,0,0,            1,0,0,32'h0,0,0);
    tbl[22] = mk(0,0,1,32'h1212_3434,3,11,0,   0,0,0,32'h0,0,0);
    tbl[23] = mk(0,1,0,32'h0,0,0,0,            1,0,0,32'h0,0,0);

    idle_inputs();
    clear2 = 0; en2 = 1; vld2 = 0; rdy2 = 0; res2 = '0; strb2 = '0; tag2 = '0;
    q.delete();
    mlanes = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1;

    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.sat_lanes", 64'(lanes2), 64'(0));
`ifdef EXPU_COLLECTOR_PROTO_CHECK_EN
    chk("rst.proto_err", 64'(perr), 64'(0));
`endif

    for (int i = 0; i < 24; i++) begin
      clear = tbl[i].clr; en = tbl[i].en; vld = tbl[i].vld; res = tbl[i].res;
      strb = tbl[i].strb; tag = tbl[i].tag; rdy = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d.ready", i), 64'(ready), 64'(tbl[i].e_ready));
      chk($sformatf("tbl%0d.valid", i), 64'(valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.busy", i),  64'(busy),  64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d.lanes", i), 64'(lanes), 64'(tbl[i].e_lanes));
      chk($sformatf("tbl%0d.data", i),  64'(data),  64'(tbl[i].e_data));
      chk($sformatf("tbl%0d.strb", i),  64'(strb_out), 64'(tbl[i].e_strb));
      chk($sformatf("tbl%0d.tag", i),   64'(tag_out), 64'(tbl[i].e_tag));
      @(posedge clk);
      #1;
    end

    // ---------------- randomized traffic against the model ----------------
    clear_all();
    for (int i = 0; i < 400; i++) begin
      clear = ($urandom_range(0, 39) == 0);
      en    = ($urandom_range(0, 7) != 0);
      vld   = ($urandom_range(0, 2) != 0);
      rdy   = ($urandom_range(0, 1) != 0);
      res   = $urandom;
      strb  = 2'($urandom_range(0, 3));
      tag   = 4'($urandom_range(0, 15));
      model_cycle($sformatf("rnd%0d", i));
    end

    // ---------------- steady streaming: one-deep, pointers wrap ----------
    clear_all();
    vld = 1; rdy = 1; res = 32'hA000_0000; strb = 3; tag = 0;
    model_cycle("stream.first");
    for (int i = 0; i < 20; i++) begin
      res = 32'hB000_0000 + 32'(i); strb = 2'($urandom_range(0, 3)); tag = 4'(i);
      model_cycle($sformatf("stream%0d", i));
      chk($sformatf("stream%0d.one_deep", i), 64'(q.size()), 64'(1));
    end

    // ---------------- reset in mid-operation ------------------------------
    vld = 1; rdy = 0; res = 32'hDEAD_BEEF; strb = 3; tag = 4'hE;
    model_cycle("prereset");
    #2;
    rst_ni = 0;
    #1;
    chk("midrst.valid", 64'(valid), 64'(0));
    chk("midrst.lanes", 64'(lanes), 64'(0));
    chk("midrst.head",  64'({data, strb_out, tag_out}), 64'(0));
    vld = 0;
    @(posedge clk);
    #1;
    rst_ni = 1;
    q.delete();
    mlanes = 0;
    idle_inputs();
    model_cycle("postrst0");
    model_cycle("postrst1");

    // ---------------- lane counter saturation at CNT_WIDTH=4 -------------
    chk("sat.init", 64'(lanes2), 64'(0));
    for (int k = 1; k <= 9; k++) begin
      vld2 = 1; rdy2 = 1; strb2 = 3; res2 = $urandom; tag2 = 4'(k);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.lanes", k), 64'(lanes2), 64'((2 * k > 15) ? 15 : 2 * k));
    end
    vld2 = 0;
    @(posedge clk);
    #1;
    chk("sat.hold", 64'(lanes2), 64'(15));

`ifdef EXPU_COLLECTOR_PROTO_CHECK_EN
    // ---------------- retracted valid while full --------------------------
    clear_all();
    chk("proto.cleared", 64'(perr), 64'(0));
    for (int k = 0; k < 4; k++) begin
      vld = 1; rdy = 0; res = 32'h100 + 32'(k); strb = 3; tag = 4'(k);
      @(posedge clk);
      #1;
    end
    chk("proto.full", 64'(ready), 64'(0));
    res = 32'h5555; tag = 4'h9;
    @(posedge clk);
    #1;
    chk("proto.held", 64'(perr), 64'(0));
    vld = 0;
    @(posedge clk);
    #1;
    chk("proto.set", 64'(perr), 64'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("proto.sticky", 64'(perr), 64'(1));
    clear = 1;
    @(posedge clk);
    #1;
    clear = 0;
    chk("proto.clr", 64'(perr), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expu_result_collector.md
Name: expu_result_collector

Overview:
- Receiving end of the exponential unit's output stream. Accepts lane vectors with strobe and tag over a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Replays the buffered vectors to the downstream normaliser/streamer over a second valid/ready handshake.
- Supplies the exponential unit's ready input, so that unit stalls only when the buffer is full.
- Counts accepted strobed lanes for softmax denominator bookkeeping.

Parameters:
- WIDTH, 16, lane width in bits (one FP element).
- N_ROWS, 1, lanes per vector.
- DEPTH, 4, FIFO entries; must be a power of two, at least 2.
- CNT_WIDTH, 32, width of the accepted-lane counter.
- TAG_TYPE, logic, sideband type carried unchanged with each vector.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous flush.
- enable_i  in  1  global enable; when low, nothing is pushed or popped and both readies are low.
- valid_i  in  1  upstream vector valid.
- res_i  in  N_ROWS*WIDTH  upstream lane data.
- strb_i  in  N_ROWS  upstream lane strobes.
- tag_i  in  $bits(TAG_TYPE)  upstream tag.
- ready_o  out  1  collector can accept; drives the exponential unit's ready input.
- valid_o  out  1  head entry valid.
- data_o  out  N_ROWS*WIDTH  head entry data; unstrobed lanes forced to zero.
- strb_o  out  N_ROWS  head entry strobes.
- tag_o  out  $bits(TAG_TYPE)  head entry tag.
- ready_i  in  1  downstream ready.
- lanes_o  out  CNT_WIDTH  running count of strobed lanes accepted.
- busy_o  out  1  FIFO non-empty.

Behaviour:
- Reset values:
  - Write pointer, read pointer and count are 0.
  - valid_o=0, busy_o=0, lanes_o=0.
  - data_o, strb_o and tag_o are 0 while empty.
  - Storage is not reset.
- Push: valid_i & ready_o.
  - ready_o = enable_i & (count != DEPTH).
  - ready_o does not depend on ready_i (no combinational path from downstream to upstream).
- Pop: valid_o & ready_i & enable_i.
  - valid_o = (count != 0); it does not depend on enable_i.
- Latency: a vector pushed in cycle t appears at the head no earlier than t+1. There is no fall-through.
- Outputs data_o, strb_o and tag_o come combinationally from the entry at the read pointer.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Push and pop in the same cycle: both pointers advance and count is unchanged.
- Full (count==DEPTH): ready_o=0 even if a pop occurs in the same cycle. The freed slot is visible the next cycle.
- Empty: valid_o=0; ready_i is ignored.
- lanes_o: incremented on every push by popcount(strb_i). It saturates at 2^CNT_WIDTH-1 and does not wrap.
- A push with strb_i=0 is stored and forwarded normally and adds 0 to lanes_o.
- clear_i (synchronous, priority over push/pop):
  - Next cycle: pointers, count and lanes_o are 0; valid_o=0.
  - A push or pop coincident with clear_i is discarded.
- enable_i low: pointers, count and lanes_o hold; ready_o=0; valid_o still reflects occupancy.
- Reset mid-operation: all state returns to reset values immediately and the contents are lost.
- busy_o = (count != 0).

Optional Feature:
- Macro: EXPU_COLLECTOR_PROTO_CHECK_EN.
- Defined: adds output port proto_err_o (1 bit, reset 0), a sticky flag cleared only by clear_i or reset. It sets when either:
  - valid_i falls while the previous cycle had valid_i & ~ready_o (valid retracted before acceptance), or
  - tag_i or res_i changes under the same condition.
  - One capture register holds the previous valid_i, tag_i and res_i.
- Undefined: no port and no check logic; the behaviour is otherwise identical.

Test Plan:
1. Reset, DEPTH=4, N_ROWS=2: ready_o=1, valid_o=0, busy_o=0, lanes_o=0. Push {0x3C00,0x4000} with strb=2'b11 and tag=1 → next cycle valid_o=1, data_o matches, tag_o=1, lanes_o=2.
2. Fill with ready_i=0 and pushes of strb 11, 01, 10, 11 → after 4 pushes ready_o=0 and lanes_o=6. A 5th vector is held off. Raise ready_i → pops appear in order, and the 01 entry shows lane1 data as 0.
3. Full with simultaneous valid_i & ready_i → only the pop occurs and ready_o=0 that cycle. Next cycle count=3 and ready_o=1.
4. Steady streaming with valid_i=1 and ready_i=1 for 20 cycles → 20 vectors out in order, count stays 1, pointers wrap 5 times without loss.
5. clear_i while count=3 and a push is asserted → next cycle valid_o=0, busy_o=0, lanes_o=0 and the pushed vector is absent. With CNT_WIDTH=4, 9 pushes of strb=2'b11 → lanes_o saturates at 15.
6. With EXPU_COLLECTOR_PROTO_CHECK_EN: while full, drop valid_i before acceptance → proto_err_o=1 the next cycle and it stays high until clear_i.
